// File: rtl/mosfet_eval_seq.sv
// mosfet_eval_seq: sequential evaluator for six MOSFETs.
// One accepted beat captures W / V_GS / V_DS for six devices plus a mode.
// A single shared multiply path evaluates one device per cycle. An
// odd/even transposition network then sorts the six values in descending
// order, and a weighted average of the top or bottom three is returned.
// Phases: IDLE -> CALC(6) -> SORT(6) -> AVG(1) -> OUT(1) -> IDLE.
// The result strobe is registered out of the OUT phase, so out_valid_o is
// high for the cycle after edge T+14 when the accept happens at edge T.
module mosfet_eval_seq #(
  parameter int IN_W  = 3,
  parameter int VAL_W = 7,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [1:0]       mode_i,
  input  logic [IN_W-1:0]  w0_i,
  input  logic [IN_W-1:0]  w1_i,
  input  logic [IN_W-1:0]  w2_i,
  input  logic [IN_W-1:0]  w3_i,
  input  logic [IN_W-1:0]  w4_i,
  input  logic [IN_W-1:0]  w5_i,
  input  logic [IN_W-1:0]  vgs0_i,
  input  logic [IN_W-1:0]  vgs1_i,
  input  logic [IN_W-1:0]  vgs2_i,
  input  logic [IN_W-1:0]  vgs3_i,
  input  logic [IN_W-1:0]  vgs4_i,
  input  logic [IN_W-1:0]  vgs5_i,
  input  logic [IN_W-1:0]  vds0_i,
  input  logic [IN_W-1:0]  vds1_i,
  input  logic [IN_W-1:0]  vds2_i,
  input  logic [IN_W-1:0]  vds3_i,
  input  logic [IN_W-1:0]  vds4_i,
  input  logic [IN_W-1:0]  vds5_i,
  output logic             busy_o,
  output logic             out_valid_o,
  output logic [OUT_W-1:0] out_n_o
);

  // Width of the shared product path; every legal product fits in 9 bits.
  localparam int PW = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_SORT,
    S_AVG,
    S_OUT
  } state_e;

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [5:0][IN_W-1:0] w_q;
  logic [5:0][IN_W-1:0] vgs_q;
  logic [5:0][IN_W-1:0] vds_q;
  logic [1:0]           mode_q;

  logic [5:0][VAL_W-1:0] val_q;
  logic [5:0][VAL_W-1:0] pass_v;
  logic [OUT_W-1:0]      avg_q, avg_d;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_n_q, out_n_d;

  logic accept;

  logic [IN_W-1:0]  sel_w, sel_vgs, sel_vds;
  logic [PW-1:0]    w9, ov9, vds9, op_b, op_c, prod;
  logic             triode;
  logic [VAL_W-1:0] dev_val;

  logic [VAL_W-1:0] avg_a, avg_b, avg_c;
  logic [OUT_W-1:0] avg_sum;

  // A new job is taken only from a truly idle block; the strobe cycle
  // that follows OUT still counts as busy.
  assign accept = (state_q == S_IDLE) && in_valid_i && !out_valid_q;

  assign busy_o      = (state_q != S_IDLE) || out_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_n_o     = out_n_q;

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; CALC and SORT each run counts 0..5.
  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CALC;
      end
      S_CALC: begin
        cnt_d = (cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_d = S_SORT;
      end
      S_SORT: begin
        cnt_d = (cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_d = S_AVG;
      end
      S_AVG:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: the result is presented for one cycle out of OUT.
  always_comb begin
    out_valid_d = 1'b0;
    out_n_d     = '0;
    if (state_q == S_OUT) begin
      out_valid_d = 1'b1;
      out_n_d     = avg_q;
    end
  end

  // Registered result strobe and value; the value is zero outside the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
    end
  end

  // Capture all device fields and the mode on accept; later port activity is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      vgs_q  <= '0;
      vds_q  <= '0;
      mode_q <= 2'd0;
    end else if (accept) begin
      w_q    <= {w5_i, w4_i, w3_i, w2_i, w1_i, w0_i};
      vgs_q  <= {vgs5_i, vgs4_i, vgs3_i, vgs2_i, vgs1_i, vgs0_i};
      vds_q  <= {vds5_i, vds4_i, vds3_i, vds2_i, vds1_i, vds0_i};
      mode_q <= mode_i;
    end
  end

  // Shared multiply path: operands are steered so one W*B*C product covers
  // current and gm in both regions, followed by a floor divide by three.
  always_comb begin
    sel_w   = w_q[cnt_q];
    sel_vgs = vgs_q[cnt_q];
    sel_vds = vds_q[cnt_q];
    w9      = PW'(sel_w);
    vds9    = PW'(sel_vds);
    ov9     = (sel_vgs != '0) ? PW'(sel_vgs) - PW'(1) : '0;
    triode  = (ov9 > vds9);
    if (mode_q[0]) begin
      if (triode) begin
        op_b = vds9;
        op_c = (ov9 << 1) - vds9;
      end else begin
        op_b = ov9;
        op_c = ov9;
      end
    end else begin
      op_b = triode ? vds9 : ov9;
      op_c = PW'(2);
    end
    prod    = w9 * op_b * op_c;
    dev_val = VAL_W'(prod / PW'(3));
  end

  // One compare-swap pass: even pairs on even counts, odd pairs on odd counts.
  always_comb begin
    pass_v = val_q;
    for (int i = 0; i < 5; i++) begin
      if (((i % 2) == int'(cnt_q[0])) && (val_q[i] < val_q[i+1])) begin
        pass_v[i]   = val_q[i+1];
        pass_v[i+1] = val_q[i];
      end
    end
  end

  // Weighted average of the selected three sorted values, floor divided by 12.
  always_comb begin
    if (mode_q[1]) begin
      avg_a = val_q[0];
      avg_b = val_q[1];
      avg_c = val_q[2];
    end else begin
      avg_a = val_q[3];
      avg_b = val_q[4];
      avg_c = val_q[5];
    end
    avg_sum = OUT_W'(avg_a) * OUT_W'(3) + OUT_W'(avg_b) * OUT_W'(4)
            + OUT_W'(avg_c) * OUT_W'(5);
    avg_d   = avg_sum / OUT_W'(12);
  end

  // Per-device results are filled during CALC, sorted in place during SORT,
  // and reduced to the final average during AVG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      avg_q <= '0;
    end else begin
      case (state_q)
        S_CALC:  val_q[cnt_q] <= dev_val;
        S_SORT:  val_q        <= pass_v;
        S_AVG:   avg_q        <= avg_d;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mosfet_eval_seq.sv
// tb_mosfet_eval_seq: directed scenarios plus random jobs for mosfet_eval_seq,
// with expected results from a plain-arithmetic device model and a queue sort.
module tb_mosfet_eval_seq;

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic [1:0] mode;
  logic [2:0] wIn   [6];
  logic [2:0] vgsIn [6];
  logic [2:0] vdsIn [6];
  logic       busy;
  logic       outValid;
  logic [9:0] outN;

  int sW   [6];
  int sVgs [6];
  int sVds [6];

  int checks = 0;
  int errors = 0;

  mosfet_eval_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inValid),
    .mode_i      (mode),
    .w0_i        (wIn[0]),
    .w1_i        (wIn[1]),
    .w2_i        (wIn[2]),
    .w3_i        (wIn[3]),
    .w4_i        (wIn[4]),
    .w5_i        (wIn[5]),
    .vgs0_i      (vgsIn[0]),
    .vgs1_i      (vgsIn[1]),
    .vgs2_i      (vgsIn[2]),
    .vgs3_i      (vgsIn[3]),
    .vgs4_i      (vgsIn[4]),
    .vgs5_i      (vgsIn[5]),
    .vds0_i      (vdsIn[0]),
    .vds1_i      (vdsIn[1]),
    .vds2_i      (vdsIn[2]),
    .vds3_i      (vdsIn[3]),
    .vds4_i      (vdsIn[4]),
    .vds5_i      (vdsIn[5]),
    .busy_o      (busy),
    .out_valid_o (outValid),
    .out_n_o     (outN)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int devModel(int w, int vgs, int vds, bit isCurrent);
    int ov;
    ov = (vgs >= 1) ? vgs - 1 : 0;
    if (ov == 0) return 0;
    if (ov > vds)
      return isCurrent ? (w * (2 * ov * vds - vds * vds)) / 3 : (2 * w * vds) / 3;
    return isCurrent ? (w * ov * ov) / 3 : (2 * w * ov) / 3;
  endfunction

  function automatic int refModel(logic [1:0] m);
    int q[$];
    for (int i = 0; i < 6; i++) q.push_back(devModel(sW[i], sVgs[i], sVds[i], m[0]));
    q.rsort();
    if (m[1]) return (3 * q[0] + 4 * q[1] + 5 * q[2]) / 12;
    return (3 * q[3] + 4 * q[4] + 5 * q[5]) / 12;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 6; i++) begin
      wIn[i]   = 3'(sW[i]);
      vgsIn[i] = 3'(sVgs[i]);
      vdsIn[i] = 3'(sVds[i]);
    end
  endtask

  task automatic scrambleInputs();
    for (int i = 0; i < 6; i++) begin
      wIn[i]   = 3'($urandom_range(0, 7));
      vgsIn[i] = 3'($urandom_range(0, 7));
      vdsIn[i] = 3'($urandom_range(0, 7));
    end
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic setAll(input int w, input int vgs, input int vds);
    for (int i = 0; i < 6; i++) begin
      sW[i]   = w;
      sVgs[i] = vgs;
      sVds[i] = vds;
    end
  endtask

  task automatic setScenario3();
    int order[6] = '{4, 7, 2, 5, 3, 6};
    for (int i = 0; i < 6; i++) begin
      sW[i]   = 3;
      sVgs[i] = order[i];
      sVds[i] = 7;
    end
  endtask

  // One full job: accept, observe 16 edges, check latency, width, busy and value.
  task automatic runJob(input logic [1:0] m, input string tag, input int fixedExp,
                        input bit poke);
    int expN, validCount, firstK, seenN;
    bit busyOk, zeroOk;
    expN = (fixedExp >= 0) ? fixedExp : refModel(m);
    @(negedge clk);
    applyStimulus();
    mode    = m;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    scrambleInputs();
    validCount = 0;
    firstK     = -1;
    seenN      = -1;
    busyOk     = 1'b1;
    zeroOk     = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (outValid === 1'b1) begin
        validCount++;
        if (firstK < 0) begin
          firstK = k;
          seenN  = int'(outN);
        end
      end else if (outN !== 10'd0) begin
        zeroOk = 1'b0;
      end
      if (k <= 14 && busy !== 1'b1) busyOk = 1'b0;
      if (k >= 15 && busy !== 1'b0) busyOk = 1'b0;
      if (poke && k == 4) begin
        scrambleInputs();
        inValid = 1'b1;
      end
      if (poke && k == 5) inValid = 1'b0;
    end
    checkOutput({tag, "_value"}, seenN, expN);
    checkOutput({tag, "_latency"}, firstK, 14);
    checkOutput({tag, "_strobes"}, validCount, 1);
    checkOutput({tag, "_busy"}, int'(busyOk), 1);
    checkOutput({tag, "_idleZero"}, int'(zeroOk), 1);
  endtask

  initial begin
    bit sawValid;
    rst_n   = 1'b0;
    inValid = 1'b0;
    mode    = 2'd0;
    setAll(0, 0, 0);
    applyStimulus();
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(outValid), 0);
    checkOutput("reset_outN", int'(outN), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    setAll(1, 3, 1);
    runJob(2'd1, "s1_m1", 1, 1'b0);
    runJob(2'd0, "s1_m0", 0, 1'b0);

    setAll(7, 7, 7);
    runJob(2'd3, "s2_m3", 84, 1'b0);
    runJob(2'd2, "s2_m2", 28, 1'b0);

    setScenario3();
    runJob(2'd3, "s3_m3", 24, 1'b0);
    runJob(2'd1, "s3_m1", 4, 1'b0);
    runJob(2'd3, "s4_poke", 24, 1'b1);

    for (int i = 0; i < 6; i++) begin
      sW[i]   = int'($urandom_range(0, 7));
      sVgs[i] = int'($urandom_range(0, 1));
      sVds[i] = int'($urandom_range(0, 7));
    end
    runJob(2'($urandom_range(0, 3)), "s5_cutoff", 0, 1'b0);

    // Abort a job with reset after edge T+8 and confirm no result appears.
    setScenario3();
    @(negedge clk);
    applyStimulus();
    mode    = 2'd3;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("s6_busyBefore", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_busyReset", int'(busy), 0);
    checkOutput("s6_validReset", int'(outValid), 0);
    checkOutput("s6_outNReset", int'(outN), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (outValid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("s6_noStrobe", int'(sawValid), 0);
    setScenario3();
    runJob(2'd3, "s6_fresh", 24, 1'b0);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 6; i++) begin
        sW[i]   = int'($urandom_range(0, 7));
        sVgs[i] = (n % 4 == 3) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
        sVds[i] = int'($urandom_range(0, 7));
      end
      runJob(2'($urandom_range(0, 3)), $sformatf("rand%0d", n), -1, n % 5 == 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
